// File: rtl/fusion_packetizer_pkg.sv
// Shared sensor-glove definitions: packet framing, flag layout, FSM states
// and the pose snapshot record carried from the fusion stage to the radio.
package fusion_packetizer_pkg;

    localparam int unsigned PKT_LEN = 12;
    localparam int unsigned IDX_W   = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    localparam int unsigned FLAG_X_BIT = 0;
    localparam int unsigned FLAG_Y_BIT = 1;
    localparam int unsigned FLAG_Z_BIT = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } pkt_state_e;

    typedef struct packed {
        logic [15:0] pitch;
        logic [15:0] roll;
        logic [15:0] yaw;
        logic [15:0] finger;
        logic        x_motion;
        logic        y_motion;
        logic        z_motion;
    } pose_sample_t;

    function automatic logic [7:0] flags_byte(input pose_sample_t s);
        logic [7:0] f;
        f             = '0;
        f[FLAG_X_BIT] = s.x_motion;
        f[FLAG_Y_BIT] = s.y_motion;
        f[FLAG_Z_BIT] = s.z_motion;
        return f;
    endfunction

    // Bytes 1..10 of a packet; header and checksum are produced by the packetizer.
    function automatic logic [7:0] payload_byte(input pose_sample_t s,
                                                input logic [7:0] seq,
                                                input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = seq;
            4'd2:    b = flags_byte(s);
            4'd3:    b = s.pitch[15:8];
            4'd4:    b = s.pitch[7:0];
            4'd5:    b = s.roll[15:8];
            4'd6:    b = s.roll[7:0];
            4'd7:    b = s.yaw[15:8];
            4'd8:    b = s.yaw[7:0];
            4'd9:    b = s.finger[15:8];
            4'd10:   b = s.finger[7:0];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fusion_packetizer_slot.sv
// One pose snapshot register with a valid flag; load wins over clear.
module fusion_pkt_slot
    import fusion_packetizer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  pose_sample_t din,
    output logic         valid,
    output pose_sample_t dout
);

    pose_sample_t data_q, data_d;
    logic         valid_q, valid_d;

    // Next-state: capture on load, otherwise drop the valid flag on clear.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = din;
            valid_d = 1'b1;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    // Snapshot storage with asynchronous reset to empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/fusion_packetizer.sv
// Pose packetizer: decimates fusion samples and streams 12-byte framed
// packets (header, seq, flags, four MSB-first words, checksum) to the UART.
module fusion_packetizer
    import fusion_packetizer_pkg::*;
#(
    parameter logic [7:0]  HEADER   = 8'hA5,
    parameter int unsigned DECIMATE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic signed [15:0] pitch,
    input  logic signed [15:0] roll,
    input  logic signed [15:0] yaw,
    input  logic signed [15:0] finger_angle,
    input  logic               x_motion,
    input  logic               y_motion,
    input  logic               z_motion,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic [7:0]         drop_count
);

    localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

    pose_sample_t     sample_in, cur_din, cur_data, pend_data;
    logic             cur_valid, pend_valid;
    logic             cur_load, cur_clear, cur_from_pend, pend_load, pend_clear;

    pkt_state_e       state_q, state_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d, next_idx;
    logic [7:0]       seq_q, seq_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       drop_q, drop_d;
    logic [7:0]       dec_cnt_q, dec_cnt_d;
    logic             drop_inc, hs, last_hs, pack_sample;

    // Gather the pose inputs into one snapshot record.
    always_comb begin
        sample_in.pitch    = pitch;
        sample_in.roll     = roll;
        sample_in.yaw      = yaw;
        sample_in.finger   = finger_angle;
        sample_in.x_motion = x_motion;
        sample_in.y_motion = y_motion;
        sample_in.z_motion = z_motion;
    end

    // Decimation: only the sample seen at count 0 becomes a packet.
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (sample_valid) begin
            dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + 8'd1;
        end
    end

    assign pack_sample = sample_valid && (dec_cnt_q == '0);
    assign hs          = tx_valid_q && tx_ready;
    assign last_hs     = (state_q == ST_SEND) && hs && (byte_idx_q == LAST_IDX);
    assign next_idx    = byte_idx_q + 1'b1;
    assign cur_din     = cur_from_pend ? pend_data : sample_in;

    // Packet sequencing: header/seq/payload/checksum byte generation, pending handling.
    // A sample arriving on the final handshake behaves as if it had been pending,
    // so the next header follows directly without passing through IDLE.
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        seq_d         = seq_q;
        chk_d         = chk_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        drop_inc      = 1'b0;
        cur_load      = 1'b0;
        cur_clear     = 1'b0;
        cur_from_pend = 1'b0;
        pend_load     = 1'b0;
        pend_clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                if (pack_sample) begin
                    state_d    = ST_SEND;
                    cur_load   = 1'b1;
                    byte_idx_d = '0;
                    tx_data_d  = HEADER;
                    tx_valid_d = 1'b1;
                    chk_d      = '0;
                end
            end
            ST_SEND: begin
                if (pack_sample && !last_hs) begin
                    pend_load = 1'b1;
                    drop_inc  = pend_valid;
                end
                if (last_hs) begin
                    seq_d      = seq_q + 8'd1;
                    byte_idx_d = '0;
                    if (pack_sample || pend_valid) begin
                        cur_load      = 1'b1;
                        cur_from_pend = !pack_sample;
                        pend_clear    = 1'b1;
                        drop_inc      = pack_sample && pend_valid;
                        tx_data_d     = HEADER;
                        chk_d         = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        cur_clear  = 1'b1;
                    end
                end else if (hs) begin
                    byte_idx_d = next_idx;
                    if (byte_idx_q != '0) begin
                        chk_d = chk_q + tx_data_q;
                    end
                    if (next_idx == LAST_IDX) begin
                        tx_data_d = chk_q + tx_data_q;
                    end else begin
                        tx_data_d = payload_byte(cur_data, seq_q, next_idx);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
        drop_d = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // FSM and registered outputs, cleared asynchronously to abandon any packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            seq_q      <= '0;
            chk_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            drop_q     <= '0;
            dec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            seq_q      <= seq_d;
            chk_q      <= chk_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            drop_q     <= drop_d;
            dec_cnt_q  <= dec_cnt_d;
        end
    end

    fusion_pkt_slot u_cur_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (cur_load),
        .clear (cur_clear),
        .din   (cur_din),
        .valid (cur_valid),
        .dout  (cur_data)
    );

    fusion_pkt_slot u_pend_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (pend_load),
        .clear (pend_clear),
        .din   (sample_in),
        .valid (pend_valid),
        .dout  (pend_data)
    );

    // The in-flight snapshot is valid exactly while a packet is being sent.
    assign busy       = cur_valid;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_fusion_packetizer.sv
// Scoreboard bench for fusion_packetizer: expected packets are queued by the
// stimulus process and popped by per-DUT monitors as bytes are handshaken.
module tb_fusion_packetizer;

    localparam logic [7:0] HDR = 8'hA5;

    typedef logic [11:0][7:0] pkt_t;
    typedef struct packed {
        logic signed [15:0] p;
        logic signed [15:0] r;
        logic signed [15:0] yw;
        logic signed [15:0] f;
        logic x;
        logic y;
        logic z;
    } smp_t;

    logic       clk, rst;
    logic       sv1, sv4, rdy1, rdy4;
    smp_t       in1, in4;
    logic [7:0] txd1, txd4, drop1, drop4;
    logic       txv1, txv4, busy1, busy4;

    int   n_assert = 0;
    int   n_fail   = 0;

    pkt_t exp1_q[$];
    pkt_t exp4_q[$];
    pkt_t cur1, cur4, e1, e4;
    int   cnt1 = 0, cnt4 = 0, pkts4 = 0;
    int   stall_idx = -1, stall_left = 0;
    bit   rand_rdy = 0, prev_stall1 = 0;
    logic [7:0] prev_d1, stall_byte;
    logic [7:0] seq1, drop1_exp;

    fusion_packetizer #(.HEADER(HDR), .DECIMATE(1)) dut1 (
        .clk(clk), .rst(rst), .sample_valid(sv1),
        .pitch(in1.p), .roll(in1.r), .yaw(in1.yw), .finger_angle(in1.f),
        .x_motion(in1.x), .y_motion(in1.y), .z_motion(in1.z),
        .tx_data(txd1), .tx_valid(txv1), .tx_ready(rdy1),
        .busy(busy1), .drop_count(drop1)
    );

    fusion_packetizer #(.HEADER(HDR), .DECIMATE(4)) dut4 (
        .clk(clk), .rst(rst), .sample_valid(sv4),
        .pitch(in4.p), .roll(in4.r), .yaw(in4.yw), .finger_angle(in4.f),
        .x_motion(in4.x), .y_motion(in4.y), .z_motion(in4.z),
        .tx_data(txd4), .tx_valid(txv4), .tx_ready(rdy4),
        .busy(busy4), .drop_count(drop4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [95:0] act, input logic [95:0] exp);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference packet built directly from the framing rules.
    function automatic pkt_t make_pkt(input smp_t s, input logic [7:0] sq);
        logic [7:0] b [12];
        int         sum;
        pkt_t       pk;
        b[0]  = HDR;
        b[1]  = sq;
        b[2]  = {5'b0, s.z, s.y, s.x};
        b[3]  = s.p[15:8];  b[4]  = s.p[7:0];
        b[5]  = s.r[15:8];  b[6]  = s.r[7:0];
        b[7]  = s.yw[15:8]; b[8]  = s.yw[7:0];
        b[9]  = s.f[15:8];  b[10] = s.f[7:0];
        sum = 0;
        for (int i = 1; i <= 10; i++) sum += int'(b[i]);
        b[11] = 8'(sum % 256);
        for (int i = 0; i < 12; i++) pk[i] = b[i];
        return pk;
    endfunction

    function automatic smp_t rand_smp();
        smp_t s;
        s.p  = 16'($urandom);
        s.r  = 16'($urandom);
        s.yw = 16'($urandom);
        s.f  = 16'($urandom);
        s.x  = 1'($urandom);
        s.y  = 1'($urandom);
        s.z  = 1'($urandom);
        return s;
    endfunction

    // Monitor for the DECIMATE=1 instance: drives tx_ready, checks hold, assembles packets.
    always @(negedge clk) begin
        if (rst) begin
            cnt1        = 0;
            prev_stall1 = 0;
            rdy1        = 1'b1;
        end else begin
            if (prev_stall1)
                chk(txv1 && (txd1 == prev_d1), "hold_while_stalled", {txv1, txd1}, {1'b1, prev_d1});
            if (txv1 && (cnt1 == stall_idx) && (stall_left > 0)) begin
                rdy1       = 1'b0;
                stall_left = stall_left - 1;
                stall_byte = txd1;
            end else if (rand_rdy) begin
                rdy1 = 1'($urandom_range(0, 1));
            end else begin
                rdy1 = 1'b1;
            end
            prev_stall1 = txv1 && !rdy1;
            prev_d1     = txd1;
            if (txv1 && rdy1) begin
                cur1[cnt1] = txd1;
                cnt1++;
                if (cnt1 == 12) begin
                    cnt1 = 0;
                    chk(exp1_q.size() > 0, "pkt1_expected", 96'(exp1_q.size()), 96'd1);
                    if (exp1_q.size() > 0) begin
                        e1 = exp1_q.pop_front();
                        chk(cur1 == e1, "pkt1_content", cur1, e1);
                    end
                end
            end
        end
    end

    // Monitor for the DECIMATE=4 instance (always ready).
    always @(negedge clk) begin
        rdy4 = 1'b1;
        if (rst) begin
            cnt4 = 0;
        end else if (txv4) begin
            cur4[cnt4] = txd4;
            cnt4++;
            if (cnt4 == 12) begin
                cnt4 = 0;
                pkts4++;
                chk(exp4_q.size() > 0, "pkt4_expected", 96'(exp4_q.size()), 96'd1);
                if (exp4_q.size() > 0) begin
                    e4 = exp4_q.pop_front();
                    chk(cur4 == e4, "pkt4_content", cur4, e4);
                end
            end
        end
    end

    task automatic drive_on1(input smp_t s);
        @(negedge clk);
        in1 = s;
        sv1 = 1'b1;
    endtask

    task automatic drive_off1();
        @(negedge clk);
        sv1 = 1'b0;
        in1 = rand_smp();
    endtask

    task automatic issue4(input smp_t s);
        @(negedge clk);
        in4 = s;
        sv4 = 1'b1;
        @(negedge clk);
        sv4 = 1'b0;
        in4 = rand_smp();
    endtask

    task automatic wait_idle1(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 800 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!busy1 && !txv1 && exp1_q.size() == 0) done = 1;
        end
        chk(done, name, 96'(done), 96'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        smp_t s, sb, sc;
        pkt_t lit;
        bit   hit;
        rst = 1'b1; sv1 = 1'b0; sv4 = 1'b0; in1 = '0; in4 = '0;
        seq1 = 8'd0; drop1_exp = 8'd0;
        repeat (3) @(negedge clk);
        chk(txv1 == 1'b0, "rst_tx_valid", 96'(txv1), 96'd0);
        chk(txd1 == 8'h00, "rst_tx_data", 96'(txd1), 96'd0);
        chk(busy1 == 1'b0, "rst_busy", 96'(busy1), 96'd0);
        chk(drop1 == 8'h00, "rst_drop", 96'(drop1), 96'd0);
        chk(txv4 == 1'b0 && busy4 == 1'b0, "rst_dut4_idle", {txv4, busy4}, 96'd0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reference vector with hand-computed bytes and first-byte latency.
        s   = '{p: 16'h1234, r: 16'hFFFE, yw: 16'h0001, f: 16'h0080, x: 1'b1, y: 1'b0, z: 1'b1};
        lit = {8'hC9, 8'h80, 8'h00, 8'h01, 8'h00, 8'hFE, 8'hFF, 8'h34, 8'h12, 8'h05, 8'h00, 8'hA5};
        exp1_q.push_back(lit); seq1++;
        drive_on1(s);
        chk(txv1 == 1'b0, "idle_before_accept", 96'(txv1), 96'd0);
        drive_off1();
        chk(txv1 && txd1 == HDR, "header_at_n_plus_1", {txv1, txd1}, {1'b1, HDR});
        chk(busy1 == 1'b1, "busy_in_send", 96'(busy1), 96'd1);
        wait_idle1("vector_timeout");

        // Back-pressure on byte 4 for three cycles.
        s = '{p: 16'h12FF, r: 16'h5A5A, yw: 16'h8001, f: 16'h7FFF, x: 1'b0, y: 1'b1, z: 1'b0};
        exp1_q.push_back(make_pkt(s, seq1)); seq1++;
        stall_idx = 4; stall_left = 3;
        drive_on1(s); drive_off1();
        wait_idle1("stall_timeout");
        chk(stall_left == 0 && stall_byte == 8'hFF, "stall_byte_held", {stall_left[7:0], stall_byte}, {8'h00, 8'hFF});
        chk(cnt1 == 0, "stall_twelve_bytes", 96'(cnt1), 96'd0);
        stall_idx = -1;

        // Three samples within one packet: middle one is overwritten.
        s  = rand_smp(); sb = rand_smp(); sc = rand_smp();
        exp1_q.push_back(make_pkt(s, seq1));  seq1++;
        exp1_q.push_back(make_pkt(sc, seq1)); seq1++;
        drop1_exp++;
        drive_on1(s);  drive_off1();
        repeat (2) @(negedge clk);
        drive_on1(sb); drive_off1();
        repeat (2) @(negedge clk);
        drive_on1(sc); drive_off1();
        wait_idle1("overwrite_timeout");
        chk(drop1 == drop1_exp, "drop_after_overwrite", 96'(drop1), 96'(drop1_exp));

        // Sample coincident with the checksum handshake.
        s  = rand_smp(); sb = rand_smp();
        lit = make_pkt(s, seq1);
        exp1_q.push_back(lit); seq1++;
        exp1_q.push_back(make_pkt(sb, seq1)); seq1++;
        drive_on1(s); drive_off1();
        repeat (10) @(negedge clk);
        drive_on1(sb);
        chk(txv1 && txd1 == lit[11], "checksum_on_accept_edge", {txv1, txd1}, {1'b1, lit[11]});
        drive_off1();
        chk(txv1 && txd1 == HDR, "back_to_back_header", {txv1, txd1}, {1'b1, HDR});
        wait_idle1("coincident_timeout");
        chk(drop1 == drop1_exp, "drop_unchanged_coincident", 96'(drop1), 96'(drop1_exp));

        // Randomized packets with random back-pressure.
        rand_rdy = 1;
        for (int k = 0; k < 16; k++) begin
            s = rand_smp();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            exp1_q.push_back(make_pkt(s, seq1)); seq1++;
            drive_on1(s); drive_off1();
            wait_idle1("random_timeout");
        end
        rand_rdy = 0;
        chk(drop1 == drop1_exp, "drop_after_random", 96'(drop1), 96'(drop1_exp));

        // Reset while byte 6 is on the bus.
        s = rand_smp();
        lit = make_pkt(s, seq1);
        exp1_q.push_back(lit);
        drive_on1(s); drive_off1();
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk); #1;
            if (cnt1 == 6) hit = 1;
        end
        chk(hit, "reach_byte6", 96'(hit), 96'd1);
        @(posedge clk); #1;
        chk(txv1 && txd1 == lit[6], "byte6_presented", {txv1, txd1}, {1'b1, lit[6]});
        rst = 1'b1;
        #1;
        chk(txv1 == 1'b0 && busy1 == 1'b0, "rst_mid_packet", {txv1, busy1}, 96'd0);
        chk(drop1 == 8'h00, "rst_clears_drop", 96'(drop1), 96'd0);
        exp1_q.delete();
        seq1 = 8'd0; drop1_exp = 8'd0;
        @(negedge clk); #2 rst = 1'b0;
        s = rand_smp();
        exp1_q.push_back(make_pkt(s, seq1)); seq1++;
        drive_on1(s); drive_off1();
        wait_idle1("post_reset_timeout");

        // Decimation by 4: samples 1 and 5 of 8 become packets.
        for (int k = 0; k < 8; k++) begin
            s = rand_smp();
            if (k % 4 == 0) exp4_q.push_back(make_pkt(s, 8'(k / 4)));
            issue4(s);
            repeat (18) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk(pkts4 == 2, "decimate_packet_count", 96'(pkts4), 96'd2);
        chk(exp4_q.size() == 0, "decimate_queue_empty", 96'(exp4_q.size()), 96'd0);
        chk(drop4 == 8'h00, "decimate_no_drop", 96'(drop4), 96'd0);
        chk(exp1_q.size() == 0 && cnt1 == 0, "dut1_drained", {exp1_q.size(), cnt1}, 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fusion_packetizer.md
FUSION_PACKETIZER -- requirements
Module: fusion_packetizer

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5: start-of-packet byte.
REQ-002 SHALL have parameter DECIMATE, default 1, range 1..255: one packet per DECIMATE accepted samples.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe from fusion stage marking a new pose sample.
REQ-006 SHALL have ports pitch, roll, yaw, finger_angle  input  16 each, signed  pose values, valid when sample_valid=1.
REQ-007 SHALL have ports x_motion, y_motion, z_motion  input  1 each  motion flags, valid when sample_valid=1.
REQ-008 SHALL have port tx_data  output  8  byte to Bluetooth UART transmitter.
REQ-009 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-010 SHALL have port tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-011 SHALL have port busy  output  1  packet in flight.
REQ-012 SHALL have port drop_count  output  8  saturating count of overwritten pending samples.

Function
REQ-013 SHALL transmit 12-byte packets: 0 HEADER; 1 seq; 2 flags {5'b0,z_motion,y_motion,x_motion}; 3-4 pitch; 5-6 roll; 7-8 yaw; 9-10 finger_angle (each MSB first); 11 checksum.
REQ-014 SHALL compute checksum as 8-bit modulo-256 sum of bytes 1..10.
REQ-015 SHALL increment seq (8-bit, wraps 255->0) after each checksum byte handshake.
REQ-016 SHALL transfer a byte only on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-017 SHALL implement FSM IDLE/SEND: IDLE->SEND on a packetized sample; SEND advances byte index 0..11 per handshake; after byte 11 -> SEND (pending present) else IDLE.
REQ-018 SHALL, for a packetized sample accepted in IDLE at cycle N, assert tx_valid with HEADER at cycle N+1.
REQ-019 SHALL snapshot all sample inputs on acceptance; input changes mid-packet SHALL not alter the packet in flight.
REQ-020 SHALL count accepted samples modulo DECIMATE; only the sample at count 0 is packetized; others discarded without drop_count change.
REQ-021 SHALL hold one pending snapshot; a packetized sample arriving in SEND loads pending.
REQ-022 SHALL, when pending is already full, overwrite it with the newer sample and increment drop_count, saturating at 255.
REQ-023 SHALL treat sample_valid coincident with the byte-11 handshake as pending: next packet starts next cycle, no IDLE cycle, no drop.
REQ-024 SHALL deassert tx_valid in IDLE; busy=1 exactly in SEND.

Reset
REQ-025 SHALL on rst force: state IDLE, tx_valid=0, tx_data=0, busy=0, drop_count=0, seq=0, byte index 0, decimation counter 0, pending empty.
REQ-026 SHALL on rst mid-packet abandon the packet; first packet after release SHALL carry seq=0.

Structure
REQ-027 SHALL take packet length (12), flag bit positions and state encoding from the shared sensor-glove package.
REQ-028 SHALL keep checksum accumulation inline; one sub-module, fusion_pkt_slot (snapshot/pending register with load/valid), instantiated twice.

Verification
REQ-029 SHALL check: DECIMATE=1, tx_ready=1, sample pitch=0x1234 roll=0xFFFE yaw=0x0001 finger=0x0080 x=1 y=0 z=1 -> bytes A5 00 05 12 34 FF FE 00 01 00 80 C9, tx_valid first at N+1.
REQ-030 SHALL check: tx_ready low 3 cycles on byte 4 -> tx_data held at 0xFF, packet unchanged, 12 bytes total.
REQ-031 SHALL check: 3 samples during one packet -> drop_count=1, next packet carries third sample with seq=1.
REQ-032 SHALL check: sample coincident with byte-11 handshake -> HEADER on next cycle, drop_count unchanged.
REQ-033 SHALL check: DECIMATE=4, 8 samples spaced 20 cycles -> exactly 2 packets, from samples 1 and 5.
REQ-034 SHALL check: rst asserted during byte 6 -> tx_valid=0 immediately; next sample yields seq=0 packet.
